// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core interrupt path: source count, vector table
// layout and the vector address helper.
package mips_pkg;

    localparam int unsigned NUM_INT_SRC     = 4;
    localparam int unsigned INT_ID_W        = 2;
    localparam logic [31:0] VEC_BASE_DFLT   = 32'h0000_01F0;
    localparam int unsigned VEC_STRIDE_DFLT = 4;

    // Jump-table entry address for source index id.
    function automatic logic [31:0] vec_addr(input logic [31:0]         base,
                                             input int unsigned         stride,
                                             input logic [INT_ID_W-1:0] id);
        logic [31:0] stride_w;
        logic [31:0] id_w;
        stride_w = stride;
        id_w     = {{(32-INT_ID_W){1'b0}}, id};
        return base + stride_w * id_w;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins; index is 0 when idle.
module int_prio_enc
    import mips_pkg::*;
(
    input  logic [NUM_INT_SRC-1:0] req,
    output logic                   valid,
    output logic [INT_ID_W-1:0]    idx
);

    // Pick the lowest-numbered active request.
    always_comb begin
        valid = |req;
        idx   = 2'd0;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else if (req[3]) begin
            idx = 2'd3;
        end
    end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt address generator: edge-detects the accelerator done
// lines, keeps sticky pending flags and drives the jump-table address that
// intmux loads into the PC on int_ack.
module vectored_int_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DFLT,
    parameter int unsigned VEC_STRIDE = VEC_STRIDE_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                int_ack,
    input  logic                done1,
    input  logic                done2,
    input  logic                done3,
    input  logic                done4,
    output logic [31:0]         int_addr,
    output logic                irq,
    output logic [INT_ID_W-1:0] int_id
);

    logic [NUM_INT_SRC-1:0] done_vec;
    logic [NUM_INT_SRC-1:0] done_q;
    logic [NUM_INT_SRC-1:0] new_edge;
    logic [NUM_INT_SRC-1:0] pending_q;
    logic [NUM_INT_SRC-1:0] pending_d;
    logic [NUM_INT_SRC-1:0] req;
    logic [NUM_INT_SRC-1:0] serve_mask;
    logic                   serve;

    assign done_vec = {done4, done3, done2, done1};
    assign new_edge = done_vec & ~done_q;
    // A fresh edge is a request this very cycle, so it can be served with no latency.
    assign req      = pending_q | new_edge;
    assign serve    = int_ack & irq;

    int_prio_enc u_prio_enc (
        .req   (req),
        .valid (irq),
        .idx   (int_id)
    );

    // Clear only the served source; every other request stays sticky.
    always_comb begin
        serve_mask = '0;
        if (serve) begin
            serve_mask[int_id] = 1'b1;
        end
        pending_d = req & ~serve_mask;
    end

    // Vector address is only presented while an interrupt is being accepted.
    always_comb begin
        int_addr = 32'h0;
        if (serve) begin
            int_addr = vec_addr(VEC_BASE, VEC_STRIDE, int_id);
        end
    end

    // Done history for edge detection and the sticky pending flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q    <= '0;
            pending_q <= '0;
        end else begin
            done_q    <= done_vec;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Self-checking bench for vectored_int_ctrl: directed scenarios followed by
// random done/ack traffic, all checked against a request-queue style model.
module tb_vectored_int_ctrl;

    logic        clk;
    logic        reset;
    logic        int_ack;
    logic        done1;
    logic        done2;
    logic        done3;
    logic        done4;
    logic [31:0] int_addr;
    logic        irq;
    logic [1:0]  int_id;

    int checks;
    int failures;

    // Reference state: which sources are owed service, and last seen done levels.
    bit model_owed [4];
    bit model_last [4];

    logic [31:0] obs_addr;
    logic        obs_irq;
    logic [1:0]  obs_id;

    vectored_int_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .int_ack  (int_ack),
        .done1    (done1),
        .done2    (done2),
        .done3    (done3),
        .done4    (done4),
        .int_addr (int_addr),
        .irq      (irq),
        .int_id   (int_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            model_owed[i] = 1'b0;
            model_last[i] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance past the edge
    // and check the pending flags against the model.
    task automatic step(input logic ack, input logic [3:0] d, input string tag);
        bit          wants [4];
        bit          any;
        int          winner;
        logic [31:0] exp_addr;
        logic [3:0]  exp_pend;
        int_ack = ack;
        {done4, done3, done2, done1} = d;
        #1;
        any    = 1'b0;
        winner = 0;
        for (int i = 0; i < 4; i++) begin
            wants[i] = model_owed[i] || (d[i] && !model_last[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (wants[i] && !any) begin
                any    = 1'b1;
                winner = i;
            end
        end
        exp_addr = (ack && any) ? 32'h1F0 + 32'(4 * winner) : 32'h0;
        obs_addr = int_addr;
        obs_irq  = irq;
        obs_id   = int_id;
        check({tag, ".irq"}, {31'b0, irq}, {31'b0, any});
        check({tag, ".id"}, {30'b0, int_id}, 32'(winner));
        check({tag, ".addr"}, int_addr, exp_addr);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            model_owed[i] = wants[i] && !(ack && any && winner == i);
            model_last[i] = d[i];
            exp_pend[i]   = model_owed[i];
        end
        #1;
        check({tag, ".pend"}, {28'b0, dut.pending_q}, {28'b0, exp_pend});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        reset    = 1'b1;
        int_ack  = 1'b0;
        {done4, done3, done2, done1} = 4'b0;
        #12;
        check("rst.irq", {31'b0, irq}, 32'h0);
        check("rst.addr", int_addr, 32'h0);
        check("rst.id", {30'b0, int_id}, 32'h0);
        @(posedge clk);
        #3 reset = 1'b0;

        // 1: pulse done2 with ack in the same cycle
        step(1'b1, 4'b0010, "t1.serve");
        check("t1.addr_lit", obs_addr, 32'h1F4);
        check("t1.id_lit", {30'b0, obs_id}, 32'h1);
        step(1'b0, 4'b0000, "t1.idle");

        // 2: done3 waits two cycles before ack
        step(1'b0, 4'b0100, "t2.rise");
        step(1'b0, 4'b0100, "t2.wait");
        step(1'b1, 4'b0100, "t2.ack");
        check("t2.addr_lit", obs_addr, 32'h1F8);
        step(1'b0, 4'b0100, "t2.after");
        check("t2.irq_lit", {31'b0, obs_irq}, 32'h0);
        step(1'b0, 4'b0000, "t2.drop");

        // 3: done1 and done4 together, served in priority order
        step(1'b1, 4'b1001, "t3.ack1");
        check("t3.addr1_lit", obs_addr, 32'h1F0);
        step(1'b1, 4'b1001, "t3.ack2");
        check("t3.addr2_lit", obs_addr, 32'h1FC);
        step(1'b0, 4'b1001, "t3.after");
        step(1'b0, 4'b0000, "t3.drop");

        // 4: done2 held high five cycles, single service
        step(1'b0, 4'b0010, "t4.c0");
        step(1'b1, 4'b0010, "t4.ack");
        step(1'b0, 4'b0010, "t4.c2");
        step(1'b1, 4'b0010, "t4.c3");
        check("t4.noreq_lit", obs_addr, 32'h0);
        step(1'b0, 4'b0010, "t4.c4");
        step(1'b0, 4'b0000, "t4.drop");

        // 5: done4 pending, asynchronous reset mid-cycle
        step(1'b0, 4'b1000, "t5.rise");
        step(1'b0, 4'b0000, "t5.pend");
        int_ack = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("t5.async_irq", {31'b0, irq}, 32'h0);
        check("t5.async_addr", int_addr, 32'h0);
        check("t5.async_pend", {28'b0, dut.pending_q}, 32'h0);
        @(posedge clk);
        #3 reset = 1'b0;
        step(1'b0, 4'b0000, "t5.post");
        step(1'b1, 4'b0000, "t5.post_ack");

        // done1 held through reset counts as a fresh edge after release
        done1 = 1'b1;
        #1 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        model_clear();
        step(1'b0, 4'b0001, "t5.held");
        check("t5.held_irq_lit", {31'b0, obs_irq}, 32'h1);
        step(1'b1, 4'b0001, "t5.held_ack");
        check("t5.held_addr_lit", obs_addr, 32'h1F0);
        step(1'b0, 4'b0000, "t5.held_drop");

        // 6: ack with no activity
        step(1'b1, 4'b0000, "t6.ack");
        check("t6.addr_lit", obs_addr, 32'h0);
        check("t6.id_lit", {30'b0, obs_id}, 32'h0);

        // Random traffic: done lines toggle sparsely, ack roughly one in three
        begin
            logic [3:0] d;
            d = 4'b0;
            for (int n = 0; n < 300; n++) begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 3) == 0) d[i] = ~d[i];
                end
                step(($urandom_range(0, 2) == 0), d, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
